// File: rtl/packet_storer.sv
// rtl/packet_storer.sv - serialises one stored packet into six acked 32-bit memory writes
module packet_storer #(
    parameter int PACKET_WIDTH = 175,
    parameter int NUM_WORDS    = 6,
    parameter int LAST_BITS    = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             opaddr_i,
    input  logic                    receive_st_valid_i,
    input  logic [31:0]             receive_st_addr_i,
    input  logic [PACKET_WIDTH-1:0] receive_st_data_i,
    output logic                    receive_st_ready_o,
    output logic                    mem_send_addr_valid_o,
    output logic [31:0]             mem_send_addr_o,
    output logic                    mem_send_data_valid_o,
    output logic [31:0]             mem_send_data_o,
    input  logic                    mem_send_ready_i,
    input  logic                    mem_receive_valid_i,
    input  logic [31:0]             mem_receive_data_i,
    output logic                    mem_receive_ready_o,
    output logic                    send_done_valid_o,
    output logic [31:0]             send_done_addr_o,
    input  logic                    send_done_ready_i
);

    typedef enum logic [1:0] {
        S_RECEIVE  = 2'd0,
        S_MEM_SEND = 2'd1,
        S_MEM_ACK  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

    state_t                  state_q, state_d;
    logic [2:0]              word_count_q, word_count_d;
    logic [31:0]             addr_q, addr_d;
    logic [PACKET_WIDTH-1:0] packet_q, packet_d;
    logic                    st_ready_q, st_ready_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    done_valid_q, done_valid_d;
    logic [31:0]             word_addr;
    logic [31:0]             word_data;

    // Write acknowledges carry no payload; only the valid strobe matters.
    logic unused_mem_data;
    assign unused_mem_data = ^mem_receive_data_i;

    // State and handshake registers; reset aborts any store in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_RECEIVE;
            word_count_q <= 3'd0;
            addr_q       <= 32'd0;
            packet_q     <= '0;
            st_ready_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            addr_q       <= addr_d;
            packet_q     <= packet_d;
            st_ready_q   <= st_ready_d;
            mem_valid_q  <= mem_valid_d;
            done_valid_q <= done_valid_d;
        end
    end

    // Next-state logic: valid/ready flags rise the cycle after entering a state.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        addr_d       = addr_q;
        packet_d     = packet_q;
        st_ready_d   = st_ready_q;
        mem_valid_d  = mem_valid_q;
        done_valid_d = done_valid_q;
        case (state_q)
            S_RECEIVE: begin
                if (st_ready_q && receive_st_valid_i) begin
                    addr_d     = receive_st_addr_i;
                    packet_d   = receive_st_data_i;
                    st_ready_d = 1'b0;
                    state_d    = S_MEM_SEND;
                end else begin
                    st_ready_d = 1'b1;
                end
            end
            S_MEM_SEND: begin
                if (mem_valid_q && mem_send_ready_i) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_MEM_ACK;
                end else begin
                    mem_valid_d = 1'b1;
                end
            end
            S_MEM_ACK: begin
                if (mem_receive_valid_i) begin
                    if (word_count_q == LAST_IDX) begin
                        word_count_d = 3'd0;
                        state_d      = S_DONE;
                    end else begin
                        word_count_d = word_count_q + 3'd1;
                        state_d      = S_MEM_SEND;
                    end
                end
            end
            default: begin
                if (done_valid_q && send_done_ready_i) begin
                    done_valid_d = 1'b0;
                    state_d      = S_RECEIVE;
                end else begin
                    done_valid_d = 1'b1;
                end
            end
        endcase
    end

    // Word selection: full words MSB-first, then the zero-extended tail.
    always_comb begin
        word_data = 32'd0;
        for (int k = 0; k < NUM_WORDS - 1; k++) begin
            if (word_count_q == k[2:0]) begin
                word_data = packet_q[PACKET_WIDTH-1-32*k -: 32];
            end
        end
        if (word_count_q == LAST_IDX) begin
            word_data = {{(32-LAST_BITS){1'b0}}, packet_q[LAST_BITS-1:0]};
        end
    end

    // Address wraps modulo 2^32; OPADDR is used live.
    assign word_addr = opaddr_i + addr_q + {27'd0, word_count_q, 2'b00};

    assign receive_st_ready_o    = st_ready_q;
    assign mem_send_addr_valid_o = mem_valid_q;
    assign mem_send_data_valid_o = mem_valid_q;
    assign mem_send_addr_o       = mem_valid_q ? word_addr : 32'd0;
    assign mem_send_data_o       = mem_valid_q ? word_data : 32'd0;
    assign mem_receive_ready_o   = (state_q == S_MEM_ACK);
    assign send_done_valid_o     = done_valid_q;
    assign send_done_addr_o      = done_valid_q ? addr_q : 32'd0;

endmodule

// File: tb/tb_packet_storer.sv
// tb/tb_packet_storer.sv - directed self-checking bench for packet_storer
module tb_packet_storer;

    logic         clk;
    logic         rst;
    logic [31:0]  opaddr;
    logic         st_valid;
    logic [31:0]  st_addr;
    logic [174:0] st_data;
    logic         st_ready;
    logic         ma_valid;
    logic [31:0]  ma_addr;
    logic         md_valid;
    logic [31:0]  md_data;
    logic         ms_ready;
    logic         mr_valid;
    logic [31:0]  mr_data;
    logic         mr_ready;
    logic         dn_valid;
    logic [31:0]  dn_addr;
    logic         dn_ready;

    int checks;
    int failures;

    logic [31:0] got_addr [0:7];
    logic [31:0] got_data [0:7];
    int          got_n;
    int          lat;

    logic [174:0] pkt1;
    logic [174:0] pkt2;
    logic [31:0]  exp1 [0:5];
    logic [31:0]  exp2 [0:5];

    packet_storer dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .opaddr_i              (opaddr),
        .receive_st_valid_i    (st_valid),
        .receive_st_addr_i     (st_addr),
        .receive_st_data_i     (st_data),
        .receive_st_ready_o    (st_ready),
        .mem_send_addr_valid_o (ma_valid),
        .mem_send_addr_o       (ma_addr),
        .mem_send_data_valid_o (md_valid),
        .mem_send_data_o       (md_data),
        .mem_send_ready_i      (ms_ready),
        .mem_receive_valid_i   (mr_valid),
        .mem_receive_data_i    (mr_data),
        .mem_receive_ready_o   (mr_ready),
        .send_done_valid_o     (dn_valid),
        .send_done_addr_o      (dn_addr),
        .send_done_ready_i     (dn_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a request and wait for the accepting edge.
    task automatic request(input logic [31:0] a, input logic [174:0] d);
        int n;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        n = 0;
        while (!st_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready", {31'd0, st_ready}, 32'd1);
        step();
        st_valid = 1'b0;
    endtask

    // Zero-wait memory: record every write until the done token appears.
    task automatic collect();
        got_n = 0;
        lat   = 0;
        ms_ready = 1'b1;
        mr_valid = 1'b1;
        while (!dn_valid && lat < 60) begin
            if (ma_valid && got_n < 8) begin
                got_addr[got_n] = ma_addr;
                got_data[got_n] = md_data;
                got_n++;
            end
            step();
            lat++;
        end
        ms_ready = 1'b0;
        mr_valid = 1'b0;
    endtask

    // One handshaked word with optional send stall, ack delay and spurious ack.
    task automatic hs_word(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                           input int send_wait, input int ack_wait, input bit spurious);
        int n;
        n = 0;
        while (!ma_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, ma_valid}, 32'd1);
        chk({tag, "_addr"}, ma_addr, ea);
        chk({tag, "_data"}, md_data, ed);
        if (spurious) begin
            chk({tag, "_rready_send"}, {31'd0, mr_ready}, 32'd0);
            mr_valid = 1'b1;
            step();
            mr_valid = 1'b0;
            chk({tag, "_spur_valid"}, {31'd0, ma_valid}, 32'd1);
            chk({tag, "_spur_addr"}, ma_addr, ea);
        end
        for (int i = 0; i < send_wait; i++) begin
            step();
            chk({tag, "_stall_valid"}, {31'd0, ma_valid & md_valid}, 32'd1);
            chk({tag, "_stall_addr"}, ma_addr, ea);
            chk({tag, "_stall_data"}, md_data, ed);
        end
        ms_ready = 1'b1;
        step();
        ms_ready = 1'b0;
        chk({tag, "_post_valid"}, {31'd0, ma_valid}, 32'd0);
        chk({tag, "_rready_ack"}, {31'd0, mr_ready}, 32'd1);
        for (int i = 0; i < ack_wait; i++) begin
            step();
            chk({tag, "_ackwait_valid"}, {31'd0, ma_valid}, 32'd0);
            chk({tag, "_ackwait_rready"}, {31'd0, mr_ready}, 32'd1);
        end
        mr_valid = 1'b1;
        step();
        mr_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        opaddr   = 32'h0000_1000;
        st_valid = 1'b0;
        st_addr  = 32'd0;
        st_data  = '0;
        ms_ready = 1'b0;
        mr_valid = 1'b0;
        mr_data  = 32'hDEAD_BEEF;
        dn_ready = 1'b0;

        pkt1 = {32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3, 32'hA4A4_A4A4, 15'h7ABC};
        exp1[0] = 32'hA0A0_A0A0; exp1[1] = 32'hA1A1_A1A1; exp1[2] = 32'hA2A2_A2A2;
        exp1[3] = 32'hA3A3_A3A3; exp1[4] = 32'hA4A4_A4A4; exp1[5] = 32'h0000_7ABC;
        pkt2 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555, 15'h1234};
        exp2[0] = 32'h1111_1111; exp2[1] = 32'h2222_2222; exp2[2] = 32'h3333_3333;
        exp2[3] = 32'h4444_4444; exp2[4] = 32'h5555_5555; exp2[5] = 32'h0000_1234;

        // Reset state
        step();
        step();
        chk("rst_st_ready", {31'd0, st_ready}, 32'd0);
        chk("rst_valids", {29'd0, ma_valid, md_valid, dn_valid}, 32'd0);
        chk("rst_mr_ready", {31'd0, mr_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("ready_after_rst", {31'd0, st_ready}, 32'd1);

        // 1: zero-wait store, latency and content
        request(32'h40, pkt1);
        chk("t1_accept_ready", {31'd0, st_ready}, 32'd0);
        collect();
        chk("t1_count", got_n, 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t1_addr%0d", i), got_addr[i], 32'h1040 + 32'(4 * i));
            chk($sformatf("t1_data%0d", i), got_data[i], exp1[i]);
        end
        chk("t1_latency", lat, 32'd19);
        chk("t1_done_addr", dn_addr, 32'h40);
        dn_ready = 1'b1;
        step();
        dn_ready = 1'b0;
        chk("t1_done_clear", {31'd0, dn_valid}, 32'd0);
        step();
        chk("t1_ready_again", {31'd0, st_ready}, 32'd1);

        // 2+3: send stall on word 2, spurious ack on word 1, ack delay on word 3
        opaddr = 32'h0000_2000;
        request(32'h100, pkt2);
        hs_word("t2w0", 32'h2100, exp2[0], 0, 0, 1'b0);
        hs_word("t3w1", 32'h2104, exp2[1], 0, 0, 1'b1);
        hs_word("t2w2", 32'h2108, exp2[2], 5, 0, 1'b0);
        hs_word("t3w3", 32'h210C, exp2[3], 0, 4, 1'b0);
        hs_word("t2w4", 32'h2110, exp2[4], 0, 0, 1'b0);
        hs_word("t2w5", 32'h2114, exp2[5], 0, 0, 1'b0);
        step();
        chk("t2_done_valid", {31'd0, dn_valid}, 32'd1);
        chk("t2_done_addr", dn_addr, 32'h100);

        // 4: token held off while a new request waits
        opaddr   = 32'hFFFF_FFF8;
        st_valid = 1'b1;
        st_addr  = 32'd0;
        st_data  = pkt1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_st_ready", {31'd0, st_ready}, 32'd0);
            chk("t4_done_held", {31'd0, dn_valid}, 32'd1);
        end
        dn_ready = 1'b1;
        step();
        dn_ready = 1'b0;
        chk("t4_ready_handoff", {31'd0, st_ready}, 32'd0);

        // 5: address wrap
        request(32'd0, pkt1);
        collect();
        chk("t5_count", got_n, 32'd6);
        chk("t5_addr0", got_addr[0], 32'hFFFF_FFF8);
        chk("t5_addr1", got_addr[1], 32'hFFFF_FFFC);
        chk("t5_addr2", got_addr[2], 32'h0000_0000);
        chk("t5_addr3", got_addr[3], 32'h0000_0004);
        chk("t5_addr4", got_addr[4], 32'h0000_0008);
        chk("t5_addr5", got_addr[5], 32'h0000_000C);
        chk("t5_data5", got_data[5], 32'h0000_7ABC);
        dn_ready = 1'b1;
        step();
        dn_ready = 1'b0;

        // 6: asynchronous reset after word 3 ack
        opaddr = 32'h0000_3000;
        request(32'h8, pkt2);
        hs_word("t6w0", 32'h3008, exp2[0], 0, 0, 1'b0);
        hs_word("t6w1", 32'h300C, exp2[1], 0, 0, 1'b0);
        hs_word("t6w2", 32'h3010, exp2[2], 0, 0, 1'b0);
        hs_word("t6w3", 32'h3014, exp2[3], 0, 0, 1'b0);
        step();
        chk("t6_w4_pending", {31'd0, ma_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valids", {29'd0, ma_valid, md_valid, dn_valid}, 32'd0);
        chk("t6_rst_readys", {30'd0, st_ready, mr_ready}, 32'd0);
        chk("t6_rst_addr", ma_addr, 32'd0);
        chk("t6_rst_data", md_data, 32'd0);
        step();
        @(negedge clk);
        rst = 1'b0;
        request(32'h8, pkt2);
        collect();
        chk("t6_count", got_n, 32'd6);
        chk("t6_restart_addr0", got_addr[0], 32'h3008);
        chk("t6_restart_data0", got_data[0], exp2[0]);
        chk("t6_restart_addr5", got_addr[5], 32'h301C);
        chk("t6_done_addr", dn_addr, 32'h8);
        dn_ready = 1'b1;
        step();
        dn_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
